// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the CPU sequencer slice: default datapath width,
//   instruction opcode field position and values, and the sequencer FSM
//   state encoding (also visible on the sequencer's state port).
package cpu_pkg;

  // Default width of program counter and instruction word
  localparam int CPU_PC_W = 16;

  // Opcode field occupies the top nibble of the instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer
//   Counts FETCH cycles that pass without an instruction-memory acknowledge.
//   Ports:
//     clk     - rising-edge clock
//     reset   - synchronous, active-low reset
//     clear   - synchronous clear (held while the sequencer is not fetching)
//     enable  - count one more unacknowledged fetch cycle
//     expired - the current fetch cycle is the LIMIT-th one; if it also ends
//               without an acknowledge the fetch has timed out
module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // count holds the number of earlier fetch cycles that ended without ack;
  // it saturates at LAST so it can never wrap back to a small value
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= {CW{1'b0}};
    end else if (clear) begin
      count <= {CW{1'b0}};
    end else if (enable && !expired) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB, with
//   free-running (run) or single-step (step) operation, fetch timeout into
//   a terminal ERROR state and a terminal HALT state for halt instructions.
//   Ports:
//     clk, reset           - clock; synchronous active-low reset
//     run, step            - free-run level; single-instruction pulse (IDLE only)
//     imem_req/addr        - fetch request and address (= pc), FETCH only
//     imem_ack/rdata       - fetch acknowledge and instruction data
//     halt_dec             - external decode: IR holds a halt instruction
//     regwrite_dec         - external decode: IR writes the register file
//     instr, pc            - instruction register, program counter
//     rf_we                - register-file write enable, WB cycle only
//     retired              - one-cycle pulse per completed instruction
//     instr_count          - saturating retired-instruction count
//     halted, err, state   - HALT flag, ERROR flag, FSM state encoding
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W          = CPU_PC_W,
  parameter logic [PC_W-1:0] RESET_PC      = {PC_W{1'b0}},
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  input  logic            halt_dec,
  input  logic            regwrite_dec,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc,
  output logic            rf_we,
  output logic            retired,
  output logic [15:0]     instr_count,
  output logic            halted,
  output logic            err,
  output logic [2:0]      state
);

  state_t fsm;
  logic   timer_clear;
  logic   timer_enable;
  logic   fetch_expired;

  // Timer restarts on every FETCH entry because it is held clear elsewhere
  assign timer_clear  = (fsm != ST_FETCH);
  assign timer_enable = (fsm == ST_FETCH) && !imem_ack;

  fetch_timer #(
    .LIMIT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (fetch_expired)
  );

  assign imem_addr = pc;
  assign state     = fsm;

  // Sequencer FSM; all outputs are registered and reflect the state entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm         <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= {PC_W{1'b0}};
      instr_count <= 16'h0000;
      imem_req    <= 1'b0;
      rf_we       <= 1'b0;
      retired     <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      rf_we    <= 1'b0;
      retired  <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          // step alongside run is indistinguishable from plain run
          if (run || step) begin
            fsm      <= ST_FETCH;
            imem_req <= 1'b1;
          end else begin
            fsm <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // an ack in the last allowed cycle still completes the fetch
          if (imem_ack) begin
            instr <= imem_rdata;
            fsm   <= ST_DECODE;
          end else if (fetch_expired) begin
            fsm <= ST_ERROR;
            err <= 1'b1;
          end else begin
            fsm      <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (halt_dec) begin
            fsm    <= ST_HALT;
            halted <= 1'b1;
          end else begin
            fsm <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // regwrite_dec decodes IR, which is stable from DECODE onward, so
          // the value sampled here is the one that applies during WB
          fsm     <= ST_WB;
          rf_we   <= regwrite_dec;
          retired <= 1'b1;
        end
        ST_WB: begin
          pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
          if (instr_count != 16'hFFFF) begin
            instr_count <= instr_count + 16'h0001;
          end else begin
            instr_count <= instr_count;
          end
          if (run) begin
            fsm      <= ST_FETCH;
            imem_req <= 1'b1;
          end else begin
            fsm <= ST_IDLE;
          end
        end
        ST_HALT: begin
          fsm    <= ST_HALT;
          halted <= 1'b1;
        end
        ST_ERROR: begin
          fsm <= ST_ERROR;
          err <= 1'b1;
        end
        default: begin
          fsm    <= ST_IDLE;
          halted <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (RESET_PC = 0) ----------------
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        halt_dec;
  logic        regwrite_dec;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        rf_we;
  logic        retired;
  logic [15:0] instr_count;
  logic        halted;
  logic        err;
  logic [2:0]  state;

  // control_unit stand-in: decode the IR
  assign halt_dec     = (instr[15:12] == OPC_HALT);
  assign regwrite_dec = (instr[15:12] == OPC_ADD);

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .halt_dec(halt_dec), .regwrite_dec(regwrite_dec),
    .instr(instr), .pc(pc), .rf_we(rf_we), .retired(retired), .instr_count(instr_count),
    .halted(halted), .err(err), .state(state)
  );

  // ---------------- DUT 2 (RESET_PC = FFFF, NOP program, instant ack) ----------------
  logic        run2 = 1'b0;
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic [15:0] instr2;
  logic [15:0] pc2;
  logic        rf_we2;
  logic        retired2;
  logic [15:0] instr_count2;
  logic        halted2;
  logic        err2;
  logic [2:0]  state2;
  logic        regwrite_dec2;
  logic [15:0] nop_word = 16'h0000;
  logic        no_step = 1'b0;
  logic        no_halt = 1'b0;

  assign regwrite_dec2 = (instr2[15:12] == OPC_ADD);

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'hFFFF), .FETCH_TIMEOUT(TMO)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .step(no_step),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(nop_word),
    .halt_dec(no_halt), .regwrite_dec(regwrite_dec2),
    .instr(instr2), .pc(pc2), .rf_we(rf_we2), .retired(retired2), .instr_count(instr_count2),
    .halted(halted2), .err(err2), .state(state2)
  );

  // ---------------- bookkeeping ----------------
  int n_check = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- instruction memory responder for DUT 1 ----------------
  logic [15:0] mem [0:15];
  int ack_delay = 0;
  bit ack_never = 1'b0;
  int req_run   = 0;

  always @(posedge clk) begin
    #1;
    if (imem_req === 1'b1) begin
      imem_ack = !ack_never && (req_run == ack_delay);
      req_run++;
    end else begin
      imem_ack = 1'b0;
      req_run  = 0;
    end
    imem_rdata = mem[imem_addr[3:0]];
  end

  // ---------------- behavioural model of DUT 1 ----------------
  // mode: idle / waiting for fetch data / instruction in flight (age 1..3
  // cycles after ack) / halted / error
  localparam int MD_IDLE = 0, MD_FETCH = 1, MD_BUSY = 2, MD_HALT = 3, MD_ERR = 4;
  bit          m_valid = 1'b0;
  int          m_mode  = MD_IDLE;
  int          m_age   = 0;
  int          m_wait  = 0;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_cnt   = 16'h0000;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_valid = 1'b1; m_mode = MD_IDLE; m_age = 0; m_wait = 0;
      m_pc = 16'h0000; m_instr = 16'h0000; m_cnt = 16'h0000;
    end else if (m_valid) begin
      case (m_mode)
        MD_IDLE: if (run || step) begin m_mode = MD_FETCH; m_wait = 0; end
        MD_FETCH: begin
          if (imem_ack) begin
            m_instr = imem_rdata; m_mode = MD_BUSY; m_age = 1;
          end else begin
            m_wait++;
            if (m_wait == TMO) m_mode = MD_ERR;
          end
        end
        MD_BUSY: begin
          if (m_age == 1 && m_instr[15:12] == OPC_HALT) m_mode = MD_HALT;
          else if (m_age == 3) begin
            m_pc = m_pc + 16'h0001;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            if (run) begin m_mode = MD_FETCH; m_wait = 0; end
            else m_mode = MD_IDLE;
          end else m_age++;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [2:0] exp_state();
    case (m_mode)
      MD_IDLE:  return ST_IDLE;
      MD_FETCH: return ST_FETCH;
      MD_BUSY:  return (m_age == 1) ? ST_DECODE : (m_age == 2) ? ST_EXEC : ST_WB;
      MD_HALT:  return ST_HALT;
      default:  return ST_ERROR;
    endcase
  endfunction

  // per-cycle comparison of DUT 1 against the model
  int ret_total = 0;
  bit rf_we2_seen = 1'b0;
  always @(negedge clk) begin
    if (retired === 1'b1) ret_total++;
    if (rf_we2 === 1'b1) rf_we2_seen = 1'b1;
    if (m_valid) begin
      check("cyc_state",   32'(state),       32'(exp_state()));
      check("cyc_req",     32'(imem_req),    32'(m_mode == MD_FETCH));
      check("cyc_addr",    32'(imem_addr),   32'(m_pc));
      check("cyc_instr",   32'(instr),       32'(m_instr));
      check("cyc_pc",      32'(pc),          32'(m_pc));
      check("cyc_rf_we",   32'(rf_we),       32'(m_mode == MD_BUSY && m_age == 3 && m_instr[15:12] == OPC_ADD));
      check("cyc_retired", 32'(retired),     32'(m_mode == MD_BUSY && m_age == 3));
      check("cyc_count",   32'(instr_count), 32'(m_cnt));
      check("cyc_halted",  32'(halted),      32'(m_mode == MD_HALT));
      check("cyc_err",     32'(err),         32'(m_mode == MD_ERR));
    end
  end

  // ---------------- stimulus helpers ----------------
  int rel_q[$];
  int req_cycles;
  bit addr_moved;
  int rf_we_seen;
  int ret_seen;

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; step = 1'b0; run2 = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Raise run and observe until n_ret retire pulses (run dropped in the last
  // WB), or halt/error, or the cycle budget runs out.
  task automatic run_insts(input int n_ret, input int budget);
    int n = 0;
    int first = -1;
    logic [15:0] first_addr = 16'h0000;
    rel_q.delete(); req_cycles = 0; addr_moved = 1'b0; rf_we_seen = 0; ret_seen = 0;
    run = 1'b1;
    while (ret_seen < n_ret && n < budget && halted !== 1'b1 && err !== 1'b1) begin
      @(negedge clk); n++;
      if (imem_req === 1'b1) begin
        if (first < 0) begin first = n; first_addr = imem_addr; end
        if (ret_seen == 0) begin
          req_cycles++;
          if (imem_addr !== first_addr) addr_moved = 1'b1;
        end
      end
      if (rf_we === 1'b1) rf_we_seen++;
      if (retired === 1'b1) begin
        ret_seen++;
        rel_q.push_back(n - first + 1);
        if (ret_seen == n_ret) run = 1'b0;
      end
    end
    if (n >= budget && ret_seen < n_ret && halted !== 1'b1 && err !== 1'b1) begin
      n_check++;
      $display("FAIL run_budget: actual=%0d retires required=%0d", ret_seen, n_ret);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int ret0;
    for (int i = 0; i < 16; i++) mem[i] = {OPC_ADD, 12'(i)};

    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_count", 32'(instr_count), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_flags", 32'({rf_we, retired, halted, err}), 32'h0);
    check("rst_pc2", 32'(pc2), 32'hFFFF);

    // three ADDs, same-cycle ack: retire at cycles 4, 8, 12
    ack_delay = 0;
    @(posedge clk); #1;
    run_insts(3, 40);
    check("run3_n", 32'(rel_q.size()), 32'd3);
    if (rel_q.size() == 3) begin
      check("run3_ret1", 32'(rel_q[0]), 32'd4);
      check("run3_ret2", 32'(rel_q[1]), 32'd8);
      check("run3_ret3", 32'(rel_q[2]), 32'd12);
    end
    check("run3_rfwe", 32'(rf_we_seen), 32'd3);
    repeat (2) @(negedge clk);
    check("run3_pc", 32'(pc), 32'h3);
    check("run3_count", 32'(instr_count), 32'd3);
    check("run3_idle", 32'(state), 32'(ST_IDLE));

    // single step; a second step during EXEC is ignored
    do_reset(2);
    ret0 = ret_total;
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    n = 0;
    while (state !== ST_EXEC && n < 20) begin @(negedge clk); n++; end
    check("step_reach_exec", 32'(state), 32'(ST_EXEC));
    step = 1'b1;
    @(negedge clk) step = 1'b0;
    repeat (6) @(negedge clk);
    check("step_retires", 32'(ret_total - ret0), 32'd1);
    check("step_pc", 32'(pc), 32'h1);
    check("step_count", 32'(instr_count), 32'd1);
    check("step_idle", 32'(state), 32'(ST_IDLE));

    // ack delayed by 5 cycles
    do_reset(2);
    ack_delay = 5;
    run_insts(1, 30);
    check("slow_req_cycles", 32'(req_cycles), 32'd6);
    check("slow_addr_stable", 32'(addr_moved), 32'd0);
    check("slow_ret_n", 32'(rel_q.size()), 32'd1);
    if (rel_q.size() == 1) check("slow_ret_cyc", 32'(rel_q[0]), 32'd9);

    // no ack at all: fetch timeout
    do_reset(2);
    ack_delay = 0; ack_never = 1'b1;
    run_insts(1, 40);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_state", 32'(state), 32'(ST_ERROR));
    check("tmo_req", 32'(imem_req), 32'd0);
    check("tmo_pc", 32'(pc), 32'h0);
    check("tmo_req_cycles", 32'(req_cycles), 32'd15);
    repeat (3) @(negedge clk);
    check("tmo_terminal", 32'(state), 32'(ST_ERROR));
    ack_never = 1'b0;
    do_reset(2);
    @(negedge clk);
    check("tmo_rst_err", 32'(err), 32'd0);
    check("tmo_rst_state", 32'(state), 32'(ST_IDLE));

    // halt instruction at pc=2
    mem[2] = {OPC_HALT, 12'h000};
    run_insts(3, 60);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_state", 32'(state), 32'(ST_HALT));
    check("halt_pc", 32'(pc), 32'h2);
    check("halt_retires", 32'(ret_seen), 32'd2);
    check("halt_rfwe", 32'(rf_we_seen), 32'd2);
    check("halt_instr", 32'(instr), 32'hF000);
    repeat (4) @(negedge clk);
    check("halt_terminal", 32'(state), 32'(ST_HALT));
    check("halt_count", 32'(instr_count), 32'd2);
    run = 1'b0;
    mem[2] = {OPC_ADD, 12'h002};

    // RESET_PC = FFFF wraps to 0000; NOP never writes the register file
    do_reset(2);
    rf_we2_seen = 1'b0;
    @(negedge clk);
    check("wrap_pc_start", 32'(pc2), 32'hFFFF);
    run2 = 1'b1;
    n = 0;
    while (retired2 !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
      if (imem_req2 === 1'b1) check("wrap_addr", 32'(imem_addr2), 32'hFFFF);
    end
    run2 = 1'b0;
    check("wrap_retired", 32'(retired2), 32'd1);
    check("wrap_rfwe_wb", 32'(rf_we2), 32'd0);
    repeat (2) @(negedge clk);
    check("wrap_pc", 32'(pc2), 32'h0000);
    check("wrap_count", 32'(instr_count2), 32'd1);
    check("wrap_idle", 32'(state2), 32'(ST_IDLE));
    check("wrap_rfwe_never", 32'(rf_we2_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, width of program counter and instruction word.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded at reset.
REQ-003 SHALL have parameter FETCH_TIMEOUT, default 15, max cycles in FETCH without imem_ack.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port run  input  1  level; free-running execution enable.
REQ-007 SHALL have port step  input  1  single-cycle pulse; execute exactly one instruction while run=0.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr  output  PC_W  fetch address (= pc).
REQ-010 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-011 SHALL have port imem_rdata  input  PC_W  fetched instruction.
REQ-012 SHALL have port halt_dec  input  1  halt decode of instr from control_unit.
REQ-013 SHALL have port regwrite_dec  input  1  RegWrite decode of instr from control_unit.
REQ-014 SHALL have port instr  output  PC_W  instruction register (IR).
REQ-015 SHALL have port pc  output  PC_W  current program counter.
REQ-016 SHALL have port rf_we  output  1  register-file write enable, gated to WB.
REQ-017 SHALL have port retired  output  1  one-cycle pulse per completed instruction.
REQ-018 SHALL have port instr_count  output  16  retired-instruction count.
REQ-019 SHALL have port halted  output  1  HALT state indicator.
REQ-020 SHALL have port err  output  1  fetch-timeout error indicator.
REQ-021 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-022 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT, ERROR.
REQ-023 IDLE SHALL go to FETCH when run=1, or when step=1 with run=0; step while run=1 SHALL be ignored.
REQ-024 step pulses in any state other than IDLE SHALL be ignored (not queued).
REQ-025 FETCH SHALL drive imem_req=1 and imem_addr=pc, held stable until imem_ack; imem_req=0 in all other states.
REQ-026 On imem_ack in FETCH, IR SHALL load imem_rdata and FSM SHALL go to DECODE; imem_ack outside FETCH SHALL be ignored.
REQ-027 FETCH timeout counter SHALL clear on FETCH entry; after FETCH_TIMEOUT cycles without ack, FSM SHALL go to ERROR; ack in the timeout cycle wins.
REQ-028 DECODE SHALL go to HALT if halt_dec=1, else to EXEC; a halt instruction SHALL NOT retire or advance pc.
REQ-029 EXEC SHALL last exactly one cycle (ALU settle), then go to WB.
REQ-030 WB SHALL drive rf_we=regwrite_dec for exactly one cycle, pulse retired, set pc<=pc+1 (wrap 16'hFFFF->16'h0000), increment instr_count saturating at 16'hFFFF.
REQ-031 After WB, FSM SHALL go to FETCH if run=1, else IDLE; run dropped mid-instruction SHALL complete the instruction first.
REQ-032 Latency with same-cycle ack SHALL be 4 cycles per instruction (FETCH, DECODE, EXEC, WB); each extra ack wait adds one cycle.
REQ-033 HALT and ERROR SHALL be terminal until reset; halted=1 only in HALT, err=1 only in ERROR.
REQ-034 rf_we SHALL be 0 outside WB regardless of regwrite_dec.

Reset
REQ-035 On reset=0 at a rising edge: state=IDLE, pc=RESET_PC, instr=0, instr_count=0, imem_req=0, rf_we=0, retired=0, halted=0, err=0, timeout counter=0.
REQ-036 Reset mid-operation (any state, including pending fetch) SHALL abandon the instruction with no rf_we or retired pulse in that cycle.

Structure
REQ-037 State encoding enum, PC_W and opcode field constants SHALL reside in shared package cpu_pkg.
REQ-038 Fetch timeout counter SHALL be one sub-module, fetch_timer (clear, enable, expired).

Verification
REQ-039 reset low 2 cycles, run=1, ack same-cycle, 3 non-halt ADD instrs -> retired at cycles 4,8,12; pc 0->1->2->3; instr_count=3.
REQ-040 run=0, one step pulse -> exactly one instruction retires, pc=1, FSM back in IDLE; second step while in EXEC ignored.
REQ-041 ack delayed 5 cycles at pc=0 -> imem_req/imem_addr stable 6 cycles, instruction retires in cycle 9.
REQ-042 no ack for 15 cycles -> err=1, state=ERROR, imem_req=0, pc unchanged; reset -> err=0, IDLE.
REQ-043 instruction with halt_dec=1 at pc=2 -> halted=1, pc=2, no retired pulse, rf_we never asserted.
REQ-044 RESET_PC=16'hFFFF, run=1, one instruction -> pc wraps to 16'h0000; regwrite_dec=0 instr -> rf_we stays 0 in WB.
